data_mem_ctrl: RTL and testbench
================================

Name: data_mem_ctrl

Overview:
- Data-memory access sequencer between the execute/memory stage and a synchronous block RAM with configurable read latency.
- Accepts one load or store at a time, generates byte enables, and sign- or zero-extends load data.
- Drives memBusy, the responder-side wait indication that the pipeline mode FSM consumes as its RAM wait input to raise MASTER_HOLD.

Parameters:
- ADDR_W, 16, byte-address width; RAM word address is ADDR_W-2 bits.
- READ_LATENCY, 2, RAM cycles from the ramEn edge to valid ramRdata; must be >= 1.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- memRead  in  1  load request; held stable by the pipeline until memBusy is low.
- memWrite  in  1  store request; same holding rule as memRead.
- funct3  in  3  RISC-V load/store size/sign field.
- addr  in  ADDR_W  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  extended load result.
- rdataValid  out  1  one-cycle pulse when a load completes.
- memBusy  out  1  stall request to the mode FSM.
- misalign  out  1  one-cycle pulse on a faulted request.
- ramAddr  out  ADDR_W-2  word address.
- ramEn  out  1  RAM enable.
- ramWe  out  4  byte write enables.
- ramWdata  out  32  lane-shifted store data.
- ramRdata  in  32  RAM read data.

Behaviour:
- Reset (asynchronous, any state): state=IDLE. rdata=0. rdataValid, misalign, ramEn, ramWe, memBusy all 0. ramAddr and ramWdata = 0.
- States and transitions:
  - IDLE to ACCESS when a legal request arrives.
  - IDLE to DONE when the request faults.
  - ACCESS to DONE when the access completes.
  - DONE to IDLE unconditionally.
- memBusy is combinational: 1 in IDLE while (memRead|memWrite) is present, and 1 throughout ACCESS. It is 0 in DONE and in IDLE with no request.
- Accept cycle T (IDLE with a request): latch addr, funct3, wdata, and direction.
  - A request with both memRead and memWrite set is treated as a store; no rdataValid pulse follows.
- Fault check at T:
  - Halfword access with addr[0]=1, or word access with addr[1:0]!=0, is misaligned.
  - Load funct3 in {011,110,111} is a fault.
  - Store funct3[2]=1 is a fault.
  - On a fault: no RAM activity; go to DONE; misalign=1 and rdata=0 in the DONE cycle.
- Cycle T+1 (first ACCESS cycle) registered outputs:
  - ramEn=1 and ramAddr=addr[ADDR_W-1:2] for exactly this cycle.
  - Store: ramWe and ramWdata are driven only in this cycle.
    - SB: ramWe=4'b0001<<addr[1:0], ramWdata=wdata[7:0] replicated x4.
    - SH: ramWe=4'b0011<<addr[1:0], ramWdata=wdata[15:0] replicated x2.
    - SW: ramWe=4'b1111, ramWdata=wdata.
- Store completion: DONE in cycle T+2.
- Load completion:
  - Down-counter loaded with READ_LATENCY at T+1.
  - ramRdata is sampled at the end of cycle T+1+READ_LATENCY.
  - DONE in cycle T+2+READ_LATENCY, with rdata registered and rdataValid=1.
  - memBusy is therefore high for READ_LATENCY+2 cycles (T through T+1+READ_LATENCY).
- Load extraction: select the byte/half by addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- DONE ignores memRead/memWrite. The request is still presented that cycle; re-acceptance happens only from IDLE on the following cycle.
- rdata holds its value until the next load or fault completes.
- Back-to-back requests: a new request is seen in IDLE at T_done+1 and accepted there.
- A request that deasserts mid-ACCESS still completes; this is a protocol violation, and the bench flags it with an assertion.
- Reset mid-ACCESS: the in-flight write is aborted if reset is asserted before the T+1 edge. No completion pulse is emitted.

Test Plan:
- LW to addr 0x0010, RAM word 0xDEADBEEF, READ_LATENCY=2 -> memBusy high 4 cycles; ramEn pulse with ramAddr=0x0004; rdata=0xDEADBEEF with rdataValid in cycle 5.
- LB addr 0x0013 and LBU addr 0x0013, word 0x80FF_0000 -> rdata=0xFFFFFF80 and rdata=0x00000080 respectively.
- SH wdata 0x1234ABCD at addr 0x0022 -> ramWe=4'b1100, ramWdata=0xABCDABCD, ramAddr=0x0008; DONE at T+2; no rdataValid.
- LW at addr 0x0006 -> misalign pulse at T+1, ramEn never asserted, memBusy high only in cycle T, rdata=0.
- Two consecutive loads, READ_LATENCY=1 -> second accepted one cycle after the first DONE; the held first request is not re-issued during DONE.
- rst_n low during the ACCESS of a load -> all outputs 0 asynchronously; after release, state is IDLE with no rdataValid pulse.

Source files
------------

// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - pipeline-side load/store request and response bundle
interface data_mem_ctrl_if #(
    parameter int ADDR_W = 16
);
    logic              memRead;
    logic              memWrite;
    logic [2:0]        funct3;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [31:0]       rdata;
    logic              rdataValid;
    logic              memBusy;
    logic              misalign;

    modport master (
        output memRead, memWrite, funct3, addr, wdata,
        input  rdata, rdataValid, memBusy, misalign
    );

    modport slave (
        input  memRead, memWrite, funct3, addr, wdata,
        output rdata, rdataValid, memBusy, misalign
    );
endinterface

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - single-outstanding load/store sequencer for a fixed-latency block RAM
module data_mem_ctrl #(
    parameter int ADDR_W       = 16,
    parameter int READ_LATENCY = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    data_mem_ctrl_if.slave     bus,
    output logic [ADDR_W-3:0]  ramAddr,
    output logic               ramEn,
    output logic [3:0]         ramWe,
    output logic [31:0]        ramWdata,
    input  logic [31:0]        ramRdata
);
    localparam int CNT_W = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t             state, state_next;
    logic               req, fault;
    logic [1:0]         size;
    logic [3:0]         we_c;
    logic [31:0]        wd_c;
    logic [1:0]         off_q;
    logic [2:0]         f3_q;
    logic               store_q;
    logic [CNT_W-1:0]   cnt;
    logic [31:0]        shifted, load_ext;

    assign req  = bus.memRead | bus.memWrite;
    assign size = bus.funct3[1:0];

    // A request with both strobes set is a store.
    always_comb begin
        fault = 1'b0;
        if (bus.memWrite) begin
            if (bus.funct3[2] || size == 2'b11) fault = 1'b1;
        end else if (size == 2'b11 || bus.funct3 == 3'b110) begin
            fault = 1'b1;
        end
        if (size == 2'b01 && bus.addr[0])          fault = 1'b1;
        if (size == 2'b10 && bus.addr[1:0] != 2'b00) fault = 1'b1;
    end

    always_comb begin
        we_c = 4'b1111;
        wd_c = bus.wdata;
        case (size)
            2'b00: begin
                we_c = 4'b0001 << bus.addr[1:0];
                wd_c = {4{bus.wdata[7:0]}};
            end
            2'b01: begin
                we_c = 4'b0011 << bus.addr[1:0];
                wd_c = {2{bus.wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        shifted  = ramRdata >> {off_q, 3'b000};
        load_ext = shifted;
        case (f3_q[1:0])
            2'b00:   load_ext = f3_q[2] ? {24'b0, shifted[7:0]}  : {{24{shifted[7]}}, shifted[7:0]};
            2'b01:   load_ext = f3_q[2] ? {16'b0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
            default: load_ext = shifted;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req) state_next = fault ? DONE : ACCESS;
            ACCESS:  if (store_q || cnt == '0) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Gated by reset so the stall drops immediately even with a request held.
    assign bus.memBusy = rst_n & (((state == IDLE) & req) | (state == ACCESS));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ramEn          <= 1'b0;
            ramWe          <= 4'b0;
            ramAddr        <= '0;
            ramWdata       <= 32'b0;
            bus.rdata      <= 32'b0;
            bus.rdataValid <= 1'b0;
            bus.misalign   <= 1'b0;
            off_q          <= 2'b0;
            f3_q           <= 3'b0;
            store_q        <= 1'b0;
            cnt            <= '0;
        end else begin
            ramEn          <= 1'b0;
            ramWe          <= 4'b0;
            ramAddr        <= '0;
            ramWdata       <= 32'b0;
            bus.rdataValid <= 1'b0;
            bus.misalign   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req) begin
                        off_q   <= bus.addr[1:0];
                        f3_q    <= bus.funct3;
                        store_q <= bus.memWrite;
                        if (fault) begin
                            bus.misalign <= 1'b1;
                            bus.rdata    <= 32'b0;
                        end else begin
                            ramEn   <= 1'b1;
                            ramAddr <= bus.addr[ADDR_W-1:2];
                            cnt     <= CNT_W'(READ_LATENCY);
                            if (bus.memWrite) begin
                                ramWe    <= we_c;
                                ramWdata <= wd_c;
                            end
                        end
                    end
                end
                ACCESS: begin
                    if (!store_q) begin
                        if (cnt == '0) begin
                            bus.rdata      <= load_ext;
                            bus.rdataValid <= 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - randomized scoreboard bench for data_mem_ctrl against a byte-level memory model
module tb_data_mem_ctrl;
    localparam int ADDR_W = 16;
    localparam int RL     = 2;

    typedef struct packed {
        logic        fault;
        logic [31:0] data;
    } resp_t;

    typedef struct packed {
        logic [ADDR_W-3:0] addr;
        logic [3:0]        we;
        logic [31:0]       wdata;
    } ramx_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_mem_ctrl_if #(.ADDR_W(ADDR_W)) m ();
    logic [ADDR_W-3:0] ramAddr;
    logic              ramEn;
    logic [3:0]        ramWe;
    logic [31:0]       ramWdata;
    logic [31:0]       ramRdata;

    data_mem_ctrl #(.ADDR_W(ADDR_W), .READ_LATENCY(RL)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (m.slave),
        .ramAddr  (ramAddr),
        .ramEn    (ramEn),
        .ramWe    (ramWe),
        .ramWdata (ramWdata),
        .ramRdata (ramRdata)
    );

    // Block RAM behind the controller: data appears RL cycles after the enable edge.
    logic [31:0] ram [64];
    logic [31:0] rd_pipe [RL];
    initial for (int i = 0; i < RL; i++) rd_pipe[i] = 32'b0;
    always @(posedge clk) begin
        if (ramEn) begin
            for (int b = 0; b < 4; b++)
                if (ramWe[b]) ram[ramAddr[5:0]][8*b +: 8] <= ramWdata[8*b +: 8];
            rd_pipe[0] <= ram[ramAddr[5:0]];
        end
        for (int i = 1; i < RL; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign ramRdata = rd_pipe[RL-1];

    logic [31:0] ref_mem [64];
    resp_t       resp_q [$];
    ramx_t       ram_q  [$];
    logic [31:0] hold_rdata = 32'b0;
    int          n_cmp  = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (m.rdataValid || m.misalign) begin
                if (resp_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_pulse: got rdataValid=%0b misalign=%0b expected none", m.rdataValid, m.misalign);
                end else begin
                    resp_t e;
                    e = resp_q.pop_front();
                    chk("resp_is_fault", {31'b0, m.misalign}, {31'b0, e.fault});
                    chk("resp_is_load", {31'b0, m.rdataValid}, {31'b0, ~e.fault});
                    chk("rdata", m.rdata, e.data);
                    hold_rdata = e.data;
                end
            end else begin
                chk("rdata_hold", m.rdata, hold_rdata);
            end
            if (ramEn) begin
                if (ram_q.size() == 0) begin
                    n_cmp++;
                    n_fail++;
                    $display("FAIL unexpected_ramEn: got ramAddr=%h ramWe=%b expected no access", ramAddr, ramWe);
                end else begin
                    ramx_t r;
                    r = ram_q.pop_front();
                    chk("ram_addr", 32'(ramAddr), 32'(r.addr));
                    chk("ram_we", {28'b0, ramWe}, {28'b0, r.we});
                    if (r.we != 4'b0) chk("ram_wdata", ramWdata, r.wdata);
                end
            end else begin
                chk("ram_we_idle", {28'b0, ramWe}, 32'b0);
            end
        end
    end

    // Pipeline protocol: a request seen while stalled must be held unchanged.
    logic              busy_s = 1'b0;
    logic [ADDR_W-1:0] addr_s;
    logic [2:0]        f3_s;
    logic              rd_s, wr_s;
    always @(posedge clk) begin
        if (rst_n && busy_s)
            assert (m.memRead == rd_s && m.memWrite == wr_s && m.addr == addr_s && m.funct3 == f3_s)
            else begin
                n_fail++;
                $display("FAIL protocol: request changed while memBusy was high");
            end
        busy_s <= m.memBusy & rst_n;
        addr_s <= m.addr;
        f3_s   <= m.funct3;
        rd_s   <= m.memRead;
        wr_s   <= m.memWrite;
    end

    // Called just after a negedge in IDLE; returns at the negedge after DONE, request still held.
    task automatic do_req(input logic rd, input logic wr, input logic [2:0] f3,
                          input logic [ADDR_W-1:0] a, input logic [31:0] wd);
        int          nbytes, exp_busy, busy;
        logic        fault;
        logic [1:0]  off;
        logic [5:0]  idx;
        logic [3:0]  we;
        logic [31:0] data, val;
        longint unsigned mask;
        nbytes = 1 << f3[1:0];
        off    = a[1:0];
        idx    = a[7:2];
        fault  = (nbytes <= 4) && ((int'(a) % nbytes) != 0);
        if (wr) fault = fault || f3[2] || (f3[1:0] == 2'b11);
        else    fault = fault || (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
        if (fault) begin
            resp_q.push_back('{fault: 1'b1, data: 32'b0});
            exp_busy = 1;
        end else if (wr) begin
            we = 4'b0;
            for (int b = 0; b < nbytes; b++) we[int'(off) + b] = 1'b1;
            for (int l = 0; l < 4; l++) data[8*l +: 8] = wd[8*(l % nbytes) +: 8];
            for (int l = 0; l < 4; l++) if (we[l]) ref_mem[idx][8*l +: 8] = data[8*l +: 8];
            ram_q.push_back('{addr: a[ADDR_W-1:2], we: we, wdata: data});
            exp_busy = 2;
        end else begin
            mask = (64'd1 << (8 * nbytes)) - 64'd1;
            val  = ref_mem[idx] >> (8 * int'(off));
            val  = val & mask[31:0];
            if (!f3[2] && val[8*nbytes-1]) val = val | ~mask[31:0];
            ram_q.push_back('{addr: a[ADDR_W-1:2], we: 4'b0, wdata: 32'b0});
            resp_q.push_back('{fault: 1'b0, data: val});
            exp_busy = RL + 2;
        end
        m.memRead  = rd;
        m.memWrite = wr;
        m.funct3   = f3;
        m.addr     = a;
        m.wdata    = wd;
        busy = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!m.memBusy) break;
            busy++;
            @(negedge clk);
        end
        chk("busy_cycles", busy, exp_busy);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        m.memRead  = 1'b0;
        m.memWrite = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        m.memRead  = 1'b0;
        m.memWrite = 1'b0;
        m.funct3   = 3'b0;
        m.addr     = '0;
        m.wdata    = 32'b0;
        repeat (3) @(negedge clk);
        chk("reset_rdata", m.rdata, 32'b0);
        chk("reset_flags", {28'b0, m.rdataValid, m.misalign, m.memBusy, ramEn}, 32'b0);
        chk("reset_ram", {28'b0, ramWe} | ramWdata | 32'(ramAddr), 32'b0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int w = 0; w < 64; w++) do_req(1'b0, 1'b1, 3'b010, 16'(w * 4), $urandom);
        idle(1);

        do_req(1'b0, 1'b1, 3'b010, 16'h0010, 32'hDEADBEEF);
        do_req(1'b1, 1'b0, 3'b010, 16'h0010, 32'h0);
        do_req(1'b0, 1'b1, 3'b010, 16'h0010, 32'h80FF_0000);
        do_req(1'b1, 1'b0, 3'b000, 16'h0013, 32'h0);
        do_req(1'b1, 1'b0, 3'b100, 16'h0013, 32'h0);
        idle(2);
        do_req(1'b0, 1'b1, 3'b001, 16'h0022, 32'h1234ABCD);
        do_req(1'b1, 1'b0, 3'b010, 16'h0020, 32'h0);
        do_req(1'b1, 1'b0, 3'b010, 16'h0006, 32'h0);
        do_req(1'b1, 1'b1, 3'b000, 16'h0031, 32'h0000_0055);
        do_req(1'b1, 1'b0, 3'b010, 16'h0030, 32'h0);

        for (int n = 0; n < 300; n++) begin
            int          r;
            logic [2:0]  f3;
            logic [15:0] a;
            r  = $urandom_range(1, 3);
            f3 = 3'($urandom_range(0, 7));
            if (r[1] && f3 == 3'b011) f3 = 3'b010;
            a  = 16'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) begin
                if (f3[1:0] == 2'b01) a[0] = 1'b0;
                if (f3[1]) a[1:0] = 2'b00;
            end
            do_req(r[0], r[1], f3, a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 3));
        end
        idle(2);

        // Reset while a load is waiting on the RAM.
        ram_q.push_back('{addr: 14'h0008, we: 4'b0, wdata: 32'b0});
        m.memRead  = 1'b1;
        m.memWrite = 1'b0;
        m.funct3   = 3'b010;
        m.addr     = 16'h0020;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b0;
        hold_rdata = 32'b0;
        #1;
        chk("async_reset_flags", {28'b0, m.rdataValid, m.misalign, m.memBusy, ramEn}, 32'b0);
        chk("async_reset_rdata", m.rdata, 32'b0);
        chk("async_reset_ram", {28'b0, ramWe} | ramWdata | 32'(ramAddr), 32'b0);
        resp_q.delete();
        @(negedge clk);
        m.memRead = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(4);
        do_req(1'b1, 1'b0, 3'b010, 16'h0010, 32'h0);
        idle(3);

        chk("resp_queue_drained", resp_q.size(), 0);
        chk("ram_queue_drained", ram_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end
endmodule
